// File: rtl/ppu_pixel_fifo_if.sv
// Fetcher/object/dot-side bundle of the PPU pixel FIFO: BG push handshake, object overlay row, pop strobe and mixed pixel.
// master = PPU-side driver, slave = the FIFO itself.
interface ppu_pixel_fifo_if #(
  parameter int PUSH_W  = 8,
  parameter int COLOR_W = 2,
  parameter int PAL_W   = 1
);
  logic                        bg_push_valid;
  logic                        bg_push_ready;
  logic [PUSH_W*COLOR_W-1:0]   bg_push_pixels;
  logic                        obj_merge_valid;
  logic [PUSH_W*COLOR_W-1:0]   obj_merge_pixels;
  logic [PAL_W-1:0]            obj_merge_pal;
  logic                        obj_merge_prio;
  logic                        pop_en;
  logic                        px_valid;
  logic [COLOR_W-1:0]          px_color;
  logic                        px_is_obj;
  logic [PAL_W-1:0]            px_pal;

  modport master (
    output bg_push_valid, bg_push_pixels,
    output obj_merge_valid, obj_merge_pixels, obj_merge_pal, obj_merge_prio,
    output pop_en,
    input  bg_push_ready,
    input  px_valid, px_color, px_is_obj, px_pal
  );

  modport slave (
    input  bg_push_valid, bg_push_pixels,
    input  obj_merge_valid, obj_merge_pixels, obj_merge_pal, obj_merge_prio,
    input  pop_en,
    output bg_push_ready,
    output px_valid, px_color, px_is_obj, px_pal
  );
endinterface

// File: rtl/ppu_pixel_fifo.sv
// BG pixel queue with an aligned OBJ overlay lane and SCX fine-scroll discard; px_* registered 1 cycle after pop_en.
// Pushes stall on bg_push_ready (count > DEPTH-PUSH_W); a push offered while not ready is dropped and sets err_overflow.
module ppu_pixel_fifo #(
  parameter int  DEPTH   = 16,
  parameter int  PUSH_W  = 8,
  parameter int  COLOR_W = 2,
  parameter int  PAL_W   = 1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            line_start,
  input  logic [2:0]      scx_fine,
  input  logic            bg_enable,
  input  logic            obj_enable,
  ppu_pixel_fifo_if.slave bus,
  output logic [CW-1:0]   count,
  output logic            err_overflow
);

  typedef enum logic [1:0] {IDLE = 2'd0, DISCARD = 2'd1, RUN = 2'd2} state_e;

  typedef struct packed {
    logic [COLOR_W-1:0] color;
    logic [PAL_W-1:0]   pal;
    logic               prio;
  } obj_slot_t;

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2:0]         discard_q, discard_d;
  logic [COLOR_W-1:0] bg_q [DEPTH];
  logic [COLOR_W-1:0] bg_d [DEPTH];
  obj_slot_t          obj_q [PUSH_W];
  obj_slot_t          obj_d [PUSH_W];
  logic               err_q, err_d;
  logic               px_valid_q, px_valid_d;
  logic [COLOR_W-1:0] px_color_q, px_color_d;
  logic               px_is_obj_q, px_is_obj_d;
  logic [PAL_W-1:0]   px_pal_q, px_pal_d;

  logic               push_rdy;
  logic               push_ok;
  logic               pop_ok;
  logic [COLOR_W-1:0] bgc;
  logic [COLOR_W-1:0] pix;
  int                 base;

  assign push_rdy = count_q <= CW'(DEPTH - PUSH_W);
  assign push_ok  = bus.bg_push_valid && push_rdy && (state_q != IDLE);
  assign pop_ok   = bus.pop_en && (count_q != '0) && (state_q != IDLE);
  assign bgc      = bg_enable ? bg_q[0] : '0;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    discard_d   = discard_q;
    bg_d        = bg_q;
    obj_d       = obj_q;
    err_d       = err_q;
    px_valid_d  = 1'b0;
    px_color_d  = '0;
    px_is_obj_d = 1'b0;
    px_pal_d    = '0;
    base        = 0;
    pix         = '0;

    if (line_start) begin
      count_d   = '0;
      discard_d = scx_fine;
      for (int i = 0; i < PUSH_W; i++) obj_d[i] = '0;
      state_d   = (scx_fine != 3'd0) ? DISCARD : RUN;
    end else begin
      if (bus.bg_push_valid && !push_rdy) err_d = 1'b1;

      // Pop shifts the queue toward the head first; the new row then lands right after the survivors.
      if (pop_ok) begin
        for (int j = 0; j < DEPTH - 1; j++) bg_d[j] = bg_q[j+1];
        bg_d[DEPTH-1] = '0;
      end
      base = int'(count_q) - (pop_ok ? 1 : 0);
      for (int j = 0; j < DEPTH; j++) begin
        if (push_ok && (j >= base) && (j < base + PUSH_W))
          bg_d[j] = bus.bg_push_pixels[(j - base)*COLOR_W +: COLOR_W];
      end
      count_d = count_q + (push_ok ? CW'(PUSH_W) : '0) - (pop_ok ? CW'(1) : '0);

      if (state_q == DISCARD) begin
        if (pop_ok) begin
          discard_d = discard_q - 3'd1;
          if (discard_d == 3'd0) state_d = RUN;
        end
      end else begin
        if (pop_ok) begin
          px_valid_d = 1'b1;
          if (obj_enable && (obj_q[0].color != '0) && !(obj_q[0].prio && (bgc != '0))) begin
            px_color_d  = obj_q[0].color;
            px_is_obj_d = 1'b1;
            px_pal_d    = obj_q[0].pal;
          end else begin
            px_color_d  = bgc;
          end
          for (int i = 0; i < PUSH_W - 1; i++) obj_d[i] = obj_q[i+1];
          obj_d[PUSH_W-1] = '0;
        end
        // Only transparent slots take new object pixels, so the earliest object keeps priority.
        if (bus.obj_merge_valid) begin
          for (int i = 0; i < PUSH_W; i++) begin
            pix = bus.obj_merge_pixels[i*COLOR_W +: COLOR_W];
            if ((obj_d[i].color == '0) && (pix != '0))
              obj_d[i] = '{color: pix, pal: bus.obj_merge_pal, prio: bus.obj_merge_prio};
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      discard_q   <= '0;
      bg_q        <= '{default: '0};
      obj_q       <= '{default: '0};
      err_q       <= 1'b0;
      px_valid_q  <= 1'b0;
      px_color_q  <= '0;
      px_is_obj_q <= 1'b0;
      px_pal_q    <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      discard_q   <= discard_d;
      bg_q        <= bg_d;
      obj_q       <= obj_d;
      err_q       <= err_d;
      px_valid_q  <= px_valid_d;
      px_color_q  <= px_color_d;
      px_is_obj_q <= px_is_obj_d;
      px_pal_q    <= px_pal_d;
    end
  end

  assign bus.bg_push_ready = push_rdy;
  assign bus.px_valid      = px_valid_q;
  assign bus.px_color      = px_color_q;
  assign bus.px_is_obj     = px_is_obj_q;
  assign bus.px_pal        = px_pal_q;
  assign count             = count_q;
  assign err_overflow      = err_q;

endmodule

// File: tb/tb_ppu_pixel_fifo.sv
// Bench for ppu_pixel_fifo: directed scanline scenarios plus random traffic against a queue-based pixel model.
module tb_ppu_pixel_fifo;
  localparam int DEPTH = 16, PUSH_W = 8, COLOR_W = 2, PAL_W = 1;

  logic       clk = 1'b0;
  logic       reset, line_start, bg_enable, obj_enable;
  logic [2:0] scx_fine;
  logic [4:0] count;
  logic       err_overflow;
  int         checks = 0;
  int         failures = 0;

  ppu_pixel_fifo_if #(.PUSH_W(PUSH_W), .COLOR_W(COLOR_W), .PAL_W(PAL_W)) bus ();

  ppu_pixel_fifo #(.DEPTH(DEPTH), .PUSH_W(PUSH_W), .COLOR_W(COLOR_W), .PAL_W(PAL_W)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .scx_fine(scx_fine),
    .bg_enable(bg_enable), .obj_enable(obj_enable), .bus(bus),
    .count(count), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  // Reference model: BG pixels as a queue, object lane as PUSH_W slots aligned to the queue head.
  logic [1:0] bgq [$];
  logic [1:0] oc [PUSH_W];
  logic       op [PUSH_W];
  logic       orr [PUSH_W];
  int         disc = 0;
  bit         started = 0;
  logic       err_m = 0, e_vld = 0, e_obj = 0, e_pal = 0;
  logic [1:0] e_col = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] row(input logic [31:0] h);
    logic [15:0] r;
    logic [3:0]  n;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      n = h[(7-i)*4 +: 4];
      r[i*2 +: 2] = n[1:0];
    end
    return r;
  endfunction

  task automatic clear_lane();
    for (int i = 0; i < PUSH_W; i++) begin oc[i] = 0; op[i] = 0; orr[i] = 0; end
  endtask

  task automatic tick();
    int sz;
    bit rdy, pop, indisc;
    logic [1:0] head, bgc, p;
    sz = bgq.size();
    if (reset) begin
      bgq.delete(); clear_lane(); disc = 0; started = 0; err_m = 0;
      e_vld = 0; e_col = 0; e_obj = 0; e_pal = 0;
    end else if (line_start) begin
      bgq.delete(); clear_lane(); disc = int'(scx_fine); started = 1;
      e_vld = 0; e_col = 0; e_obj = 0; e_pal = 0;
    end else begin
      rdy = (sz <= DEPTH - PUSH_W);
      if (bus.bg_push_valid && !rdy) err_m = 1;
      pop = bus.pop_en && sz > 0 && started;
      indisc = disc > 0;
      e_vld = 0; e_col = 0; e_obj = 0; e_pal = 0;
      if (pop) begin
        head = bgq.pop_front();
        if (indisc) disc--;
        else begin
          e_vld = 1;
          bgc = bg_enable ? head : 2'd0;
          if (obj_enable && oc[0] != 0 && !(orr[0] && bgc != 0)) begin
            e_col = oc[0]; e_obj = 1; e_pal = op[0];
          end else e_col = bgc;
          for (int i = 0; i < PUSH_W - 1; i++) begin oc[i] = oc[i+1]; op[i] = op[i+1]; orr[i] = orr[i+1]; end
          oc[PUSH_W-1] = 0; op[PUSH_W-1] = 0; orr[PUSH_W-1] = 0;
        end
      end
      if (bus.obj_merge_valid && !indisc) begin
        for (int i = 0; i < PUSH_W; i++) begin
          p = bus.obj_merge_pixels[i*2 +: 2];
          if (oc[i] == 0 && p != 0) begin oc[i] = p; op[i] = bus.obj_merge_pal; orr[i] = bus.obj_merge_prio; end
        end
      end
      if (bus.bg_push_valid && rdy && started)
        for (int i = 0; i < PUSH_W; i++) bgq.push_back(bus.bg_push_pixels[i*2 +: 2]);
    end
    @(posedge clk);
    #1;
    chk("m_vld", bus.px_valid, e_vld);
    chk("m_col", bus.px_color, e_col);
    chk("m_obj", bus.px_is_obj, e_obj);
    chk("m_pal", bus.px_pal, e_pal);
    chk("m_count", count, bgq.size());
    chk("m_ready", bus.bg_push_ready, bgq.size() <= DEPTH - PUSH_W);
    chk("m_err", err_overflow, err_m);
  endtask

  task automatic idle_inputs();
    reset = 0; line_start = 0;
    bus.bg_push_valid = 0; bus.obj_merge_valid = 0; bus.pop_en = 0;
  endtask

  task automatic do_line(input logic [2:0] scx);
    line_start = 1; scx_fine = scx; tick(); line_start = 0;
  endtask

  task automatic do_push(input logic [31:0] h);
    bus.bg_push_valid = 1; bus.bg_push_pixels = row(h); tick(); bus.bg_push_valid = 0;
  endtask

  task automatic do_merge(input logic [31:0] h, input logic pal, input logic prio);
    bus.obj_merge_valid = 1; bus.obj_merge_pixels = row(h);
    bus.obj_merge_pal = pal; bus.obj_merge_prio = prio;
    tick(); bus.obj_merge_valid = 0;
  endtask

  // Pops n pixels; each must be valid with the colour/source/palette given per pixel (pixel 0 leftmost).
  task automatic pop_row(input string tag, input int n, input logic [31:0] ecol,
                         input logic [7:0] eobj, input logic [7:0] epal);
    logic [3:0] c;
    for (int i = 0; i < n; i++) begin
      bus.pop_en = 1; tick(); bus.pop_en = 0;
      c = ecol[(7-i)*4 +: 4];
      chk({tag, "_vld"}, bus.px_valid, 1);
      chk({tag, "_col"}, bus.px_color, c[1:0]);
      chk({tag, "_obj"}, bus.px_is_obj, eobj[i]);
      chk({tag, "_pal"}, bus.px_pal, epal[i]);
    end
  endtask

  initial begin
    idle_inputs();
    scx_fine = 0; bg_enable = 1; obj_enable = 1;
    bus.bg_push_pixels = '0; bus.obj_merge_pixels = '0;
    bus.obj_merge_pal = 0; bus.obj_merge_prio = 0;

    reset = 1; tick(); reset = 0;
    chk("rst_count", count, 0);
    chk("rst_ready", bus.bg_push_ready, 1);
    chk("rst_vld", bus.px_valid, 0);
    chk("rst_col", bus.px_color, 0);
    chk("rst_err", err_overflow, 0);

    do_line(3'd0);
    do_push(32'h01230123);
    chk("t1_count", count, 8);
    tick();
    chk("t1_nopop_vld", bus.px_valid, 0);
    pop_row("t1", 8, 32'h01230123, 8'h00, 8'h00);

    do_line(3'd3);
    do_push(32'h12301230);
    for (int i = 0; i < 3; i++) begin
      bus.pop_en = 1; tick(); bus.pop_en = 0;
      chk("t2_disc_vld", bus.px_valid, 0);
    end
    pop_row("t2", 5, 32'h01230000, 8'h00, 8'h00);
    chk("t2_empty", count, 0);

    do_line(3'd0);
    do_push(32'h11111111);
    do_push(32'h22222222);
    for (int i = 0; i < 7; i++) begin bus.pop_en = 1; tick(); end
    bus.pop_en = 0;
    chk("t3_count9", count, 9);
    chk("t3_not_ready", bus.bg_push_ready, 0);
    do_push(32'h33333333);
    chk("t3_dropped", count, 9);
    chk("t3_err", err_overflow, 1);
    tick(); tick();
    chk("t3_err_sticky", err_overflow, 1);

    do_line(3'd0);
    do_push(32'h11111111);
    do_merge(32'h02200000, 1'b1, 1'b0);
    pop_row("t4a", 8, 32'h12211111, 8'b0000_0110, 8'b0000_0110);
    do_line(3'd0);
    do_push(32'h11111111);
    do_merge(32'h02200000, 1'b1, 1'b1);
    pop_row("t4b", 8, 32'h11111111, 8'h00, 8'h00);
    do_line(3'd0);
    bg_enable = 0;
    do_push(32'h11111111);
    do_merge(32'h02200000, 1'b1, 1'b1);
    pop_row("t4c", 8, 32'h02200000, 8'b0000_0110, 8'b0000_0110);
    bg_enable = 1;

    do_line(3'd0);
    do_push(32'h11111111);
    do_merge(32'h30000000, 1'b0, 1'b0);
    do_merge(32'h22000000, 1'b1, 1'b0);
    pop_row("t5", 8, 32'h32111111, 8'b0000_0011, 8'b0000_0010);

    do_line(3'd0);
    do_push(32'h01230123);
    bus.bg_push_valid = 1; bus.pop_en = 1; bus.bg_push_pixels = row(32'h32103210);
    tick();
    chk("t6_count15", count, 15);
    line_start = 1; scx_fine = 0;
    tick();
    idle_inputs();
    chk("t6_ls_count", count, 0);
    chk("t6_ls_vld", bus.px_valid, 0);

    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 499) == 0);
      line_start = ($urandom_range(0, 39) == 0);
      scx_fine = 3'($urandom_range(0, 7));
      bg_enable = ($urandom_range(0, 9) != 0);
      obj_enable = ($urandom_range(0, 9) != 0);
      bus.bg_push_valid = ($urandom_range(0, 2) == 0);
      bus.bg_push_pixels = 16'($urandom);
      bus.obj_merge_valid = ($urandom_range(0, 5) == 0);
      bus.obj_merge_pixels = 16'($urandom);
      bus.obj_merge_pal = 1'($urandom_range(0, 1));
      bus.obj_merge_prio = 1'($urandom_range(0, 1));
      bus.pop_en = 1'($urandom_range(0, 1));
      tick();
    end
    idle_inputs();
    reset = 1; tick(); reset = 0;
    chk("end_rst_err", err_overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
